dpi_flow_ctx_feeder: RTL and testbench
======================================

// Module: dpi_flow_ctx_feeder
// PURPOSE
//  Drives one DFA regex matcher from a packet byte stream that interleaves many flows.
//  On each start of packet (SOP) it restores that flow's saved DFA state into the matcher.
//  It then streams the payload bytes and, on end of packet (EOP), saves the matcher's final state back.
//  Matches are reported tagged with flow id and byte offset. Sits between the packet parser and the matcher.
// PARAMETERS
//  STATE_W  11  matcher state width (state_in/state_out)
//  FLOW_W    6  flow id width; context RAM depth = 2**FLOW_W
//  OFS_W    16  byte-offset counter width (saturating)
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous reset, active-high
//  pkt_vld        in   1        input byte valid
//  pkt_rdy        out  1        input byte accepted when pkt_vld & pkt_rdy
//  pkt_data       in   8        payload byte
//  pkt_sop        in   1        first byte of packet
//  pkt_eop        in   1        last byte of packet
//  pkt_flow       in   FLOW_W   flow id, sampled on SOP beat
//  m_char         out  8        to matcher char_in (= pkt_data)
//  m_char_vld     out  1        to matcher char_in_vld
//  m_state_in     out  STATE_W  to matcher state_in
//  m_state_in_vld out  1        to matcher state_in_vld
//  m_state_out    in   STATE_W  from matcher state_out
//  m_accept       in   1        from matcher accept_out (combinational, same cycle as m_char_vld)
//  ctx_clr_vld    in   1        request: zero context of ctx_clr_flow
//  ctx_clr_flow   in   FLOW_W   flow to clear
//  ctx_clr_rdy    out  1        clear accepted when ctx_clr_vld & ctx_clr_rdy
//  match_vld      out  1        1-cycle pulse: match reported
//  match_flow     out  FLOW_W   flow of match
//  match_ofs      out  OFS_W    byte offset within packet of matching byte (first byte = 0)
//  err            out  1        1-cycle pulse: protocol error
//  busy           out  1        high while context init sweep runs
// BEHAVIOUR
//  Reset values: all outputs 0 except busy=1. FSM enters INIT. Any rst mid-packet aborts it and re-inits all contexts.
//  INIT: writes 0 to RAM[0..2**FLOW_W-1], one entry per cycle, then goes to IDLE with busy=0. pkt_rdy=0 throughout.
//  IDLE:
//   - ctx_clr_rdy=1. An accepted clear writes RAM[ctx_clr_flow]=0; stay IDLE. A clear has priority over a pending SOP.
//   - pkt_rdy=0 when pkt_vld & pkt_sop: the SOP beat is held. Latch pkt_flow, issue RAM read, go RD.
//   - A non-SOP beat is accepted and dropped (pkt_rdy=1), err pulses.
//  RD: RAM synchronous read, 1-cycle latency. Go RESTORE.
//  RESTORE: m_state_in=RAM q, m_state_in_vld=1 for exactly 1 cycle. Offset counter cleared. Go STREAM.
//  STREAM: pkt_rdy=1 except on an SOP beat.
//   - m_char_vld = pkt_vld & pkt_rdy, combinational.
//   - Each accepted byte increments ofs, saturating at 2**OFS_W-1.
//   - The EOP beat (including SOP+EOP in one beat, which is accepted here) moves to SAVE.
//   - An SOP beat arriving without a prior EOP is not accepted: err pulses and the FSM goes SAVE.
//     The new packet is then handled from IDLE.
//  SAVE: RAM[flow]=m_state_out (matcher updated on last accept edge). Go IDLE. Min packet cost = 4 cycles + bytes.
//  Match: match_vld registered 1 cycle after accepted byte with m_accept=1; match_flow, match_ofs of that byte.
//  m_state_in_vld and m_char_vld never both 1. No clear accepted outside IDLE, so there is no RAM write/read hazard.
// STRUCTURE
//  dpi_ctx_pkg: FSM state enum (INIT,IDLE,RD,RESTORE,STREAM,SAVE), STATE_W/FLOW_W defaults.
//  Sub-module dpi_ctx_ram: simple dual-port, 1 write + 1 sync read, depth 2**FLOW_W, width STATE_W.
// TESTING
//  1 Release rst: busy=1 and pkt_rdy=0 for 64 cycles, then busy=0 and ctx_clr_rdy=1.
//  2 Flow 3, bytes "USER " with matcher model accepting after the space.
//    -> m_state_in_vld with m_state_in=0, match_vld next cycle with flow=3, ofs=4.
//  3 Flow 5 "US"+EOP, flow 7 "xx"+EOP, flow 5 "ER "+EOP.
//    -> flow-5 restore equals state saved after "US"; match ofs=2 in packet 3.
//  4 SOP+EOP single byte on flow 9 -> RD, RESTORE, STREAM (1 m_char_vld), SAVE writes m_state_out to RAM[9].
//  5 After test 3 with a partial state, clear flow 5 in IDLE -> next flow-5 packet restores m_state_in=0.
//  6 SOP beat mid-packet (no EOP) -> err pulse, old flow saved, new SOP held then restored normally.
//    Also: a non-SOP beat in IDLE -> accepted, err pulse.

Source files
------------

// File: rtl/dpi_flow_ctx_feeder_pkg.sv
// Shared types and default widths for the per-flow DFA context feeder.
package dpi_ctx_pkg;

   localparam int STATE_W_DEF = 11;
   localparam int FLOW_W_DEF  = 6;
   localparam int OFS_W_DEF   = 16;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_RD      = 3'd2,
      ST_RESTORE = 3'd3,
      ST_STREAM  = 3'd4,
      ST_SAVE    = 3'd5
   } fsm_t;

endpackage

// File: rtl/dpi_flow_ctx_feeder_ram.sv
// Per-flow DFA context store: one write port, one registered read port.
module dpi_ctx_ram #(
   parameter int AW = 6,
   parameter int DW = 11
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // NOTE: the array has no reset; the feeder's INIT sweep zeroes it, which keeps this a plain RAM macro.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/dpi_flow_ctx_feeder.sv
// Restores a flow's DFA state on SOP, streams payload into the matcher, saves the state on EOP.
module dpi_flow_ctx_feeder
   import dpi_ctx_pkg::*;
#(
   parameter int STATE_W = STATE_W_DEF,
   parameter int FLOW_W  = FLOW_W_DEF,
   parameter int OFS_W   = OFS_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pkt_vld,
   output logic               pkt_rdy,
   input  logic [7:0]         pkt_data,
   input  logic               pkt_sop,
   input  logic               pkt_eop,
   input  logic [FLOW_W-1:0]  pkt_flow,
   output logic [7:0]         m_char,
   output logic               m_char_vld,
   output logic [STATE_W-1:0] m_state_in,
   output logic               m_state_in_vld,
   input  logic [STATE_W-1:0] m_state_out,
   input  logic               m_accept,
   input  logic               ctx_clr_vld,
   input  logic [FLOW_W-1:0]  ctx_clr_flow,
   output logic               ctx_clr_rdy,
   output logic               match_vld,
   output logic [FLOW_W-1:0]  match_flow,
   output logic [OFS_W-1:0]   match_ofs,
   output logic               err,
   output logic               busy
);

   fsm_t               state, state_nxt;
   logic [FLOW_W-1:0]  init_cnt;
   logic [FLOW_W-1:0]  flow_q;
   logic [OFS_W-1:0]   ofs_q;
   logic               first_q;
   logic               err_set;
   logic               sop_abort;

   logic               ram_we;
   logic [FLOW_W-1:0]  ram_waddr;
   logic [STATE_W-1:0] ram_wdata;
   logic               ram_re;
   logic [STATE_W-1:0] ram_q;

   dpi_ctx_ram #(
      .AW (FLOW_W),
      .DW (STATE_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (flow_q),
      .rdata (ram_q)
   );

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt      = state;
      pkt_rdy        = 1'b0;
      ctx_clr_rdy    = 1'b0;
      ram_we         = 1'b0;
      ram_waddr      = init_cnt;
      ram_wdata      = '0;
      ram_re         = 1'b0;
      err_set        = 1'b0;
      sop_abort      = 1'b0;
      m_state_in_vld = 1'b0;
      busy           = 1'b0;
      case (state)
         ST_INIT: begin
            busy   = 1'b1;
            ram_we = 1'b1;
            if (init_cnt == '1) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            ctx_clr_rdy = 1'b1;
            pkt_rdy     = ~(pkt_vld & pkt_sop);
            err_set     = pkt_vld & ~pkt_sop;
            // A clear wins over a waiting SOP; the SOP beat stays held until the next cycle.
            if (ctx_clr_vld) begin
               ram_we    = 1'b1;
               ram_waddr = ctx_clr_flow;
            end else if (pkt_vld && pkt_sop) begin
               state_nxt = ST_RD;
            end
         end
         ST_RD: begin
            ram_re    = 1'b1;
            state_nxt = ST_RESTORE;
         end
         ST_RESTORE: begin
            m_state_in_vld = 1'b1;
            state_nxt      = ST_STREAM;
         end
         ST_STREAM: begin
            // Only the packet's own held SOP beat may carry sop; any later SOP means a lost EOP.
            sop_abort = pkt_vld & pkt_sop & ~first_q;
            pkt_rdy   = ~sop_abort;
            if (sop_abort) begin
               err_set   = 1'b1;
               state_nxt = ST_SAVE;
            end else if (pkt_vld && pkt_eop) begin
               state_nxt = ST_SAVE;
            end
         end
         ST_SAVE: begin
            ram_we    = 1'b1;
            ram_waddr = flow_q;
            ram_wdata = m_state_out;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   assign m_char     = pkt_data;
   assign m_char_vld = (state == ST_STREAM) & pkt_vld & pkt_rdy;
   assign m_state_in = (state == ST_RESTORE) ? ram_q : '0;

   // NOTE: all state below uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_INIT;
         init_cnt   <= '0;
         flow_q     <= '0;
         ofs_q      <= '0;
         first_q    <= 1'b0;
         match_vld  <= 1'b0;
         match_flow <= '0;
         match_ofs  <= '0;
         err        <= 1'b0;
      end else begin
         state     <= state_nxt;
         err       <= err_set;
         match_vld <= m_char_vld & m_accept;
         if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
         if (state == ST_IDLE && state_nxt == ST_RD) flow_q <= pkt_flow;
         if (state == ST_RESTORE) begin
            ofs_q   <= '0;
            first_q <= 1'b1;
         end
         if (m_char_vld) begin
            match_flow <= flow_q;
            match_ofs  <= ofs_q;
            first_q    <= 1'b0;
            if (ofs_q != '1) ofs_q <= ofs_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dpi_flow_ctx_feeder.sv
// Scoreboard bench for dpi_flow_ctx_feeder with a small "USER " DFA standing in for the matcher.
module tb_dpi_flow_ctx_feeder;

   localparam int STATE_W = 11;
   localparam int FLOW_W  = 6;
   localparam int OFS_W   = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic               pkt_vld, pkt_rdy, pkt_sop, pkt_eop;
   logic [7:0]         pkt_data;
   logic [FLOW_W-1:0]  pkt_flow;
   logic [7:0]         m_char;
   logic               m_char_vld, m_state_in_vld, m_accept;
   logic [STATE_W-1:0] m_state_in, m_state_out;
   logic               ctx_clr_vld, ctx_clr_rdy;
   logic [FLOW_W-1:0]  ctx_clr_flow;
   logic               match_vld, err, busy;
   logic [FLOW_W-1:0]  match_flow;
   logic [OFS_W-1:0]   match_ofs;

   always #5 clk = ~clk;

   dpi_flow_ctx_feeder #(.STATE_W(STATE_W), .FLOW_W(FLOW_W), .OFS_W(OFS_W)) dut (
      .clk(clk), .rst(rst),
      .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_data(pkt_data),
      .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_flow(pkt_flow),
      .m_char(m_char), .m_char_vld(m_char_vld),
      .m_state_in(m_state_in), .m_state_in_vld(m_state_in_vld),
      .m_state_out(m_state_out), .m_accept(m_accept),
      .ctx_clr_vld(ctx_clr_vld), .ctx_clr_flow(ctx_clr_flow), .ctx_clr_rdy(ctx_clr_rdy),
      .match_vld(match_vld), .match_flow(match_flow), .match_ofs(match_ofs),
      .err(err), .busy(busy)
   );

   // Matcher stand-in: DFA for "USER ", state 5 = accept.
   logic [STATE_W-1:0] mst, mnxt;

   function automatic logic [STATE_W-1:0] dfa_next(input logic [STATE_W-1:0] s, input logic [7:0] c);
      logic [7:0] e;
      case (s)
         11'd0:   e = 8'h55;
         11'd1:   e = 8'h53;
         11'd2:   e = 8'h45;
         11'd3:   e = 8'h52;
         11'd4:   e = 8'h20;
         default: e = 8'h00;
      endcase
      if (s < 11'd5 && c == e) return s + 11'd1;
      else if (c == 8'h55)     return 11'd1;
      else                     return 11'd0;
   endfunction

   always_comb begin
      mnxt        = dfa_next(mst, m_char);
      m_accept    = m_char_vld && (mnxt == 11'd5);
      m_state_out = mst;
   end

   always_ff @(posedge clk) begin
      if (rst)                 mst <= '0;
      else if (m_state_in_vld) mst <= m_state_in;
      else if (m_char_vld)     mst <= mnxt;
   end

   typedef struct {
      logic [FLOW_W-1:0] flow;
      logic [OFS_W-1:0]  ofs;
   } match_t;

   logic [STATE_W-1:0] rq[$];
   match_t             mq[$];
   int                 err_exp = 0;
   int                 vectors = 0;
   int                 miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a restore, match or error.
   initial begin
      logic [STATE_W-1:0] e_state;
      match_t             e_match;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (m_state_in_vld || m_char_vld) check("vld_exclusive", m_state_in_vld & m_char_vld, 0);
            if (m_state_in_vld) begin
               check("restore_expected", rq.size() != 0, 1);
               if (rq.size() != 0) begin
                  e_state = rq.pop_front();
                  check("restore_state", m_state_in, e_state);
               end
            end
            if (match_vld) begin
               check("match_expected", mq.size() != 0, 1);
               if (mq.size() != 0) begin
                  e_match = mq.pop_front();
                  check("match_flow", match_flow, e_match.flow);
                  check("match_ofs", match_ofs, e_match.ofs);
               end
            end
            if (err) begin
               check("err_expected", err_exp > 0, 1);
               if (err_exp > 0) err_exp--;
            end
         end
      end
   end

   // Called at a negedge; holds the beat until accepted or the cycle budget runs out.
   task automatic beat(input logic [7:0] d, input logic sop, input logic eop, input logic [FLOW_W-1:0] fl);
      int   cyc;
      logic acc;
      pkt_vld  = 1'b1;
      pkt_data = d;
      pkt_sop  = sop;
      pkt_eop  = eop;
      pkt_flow = fl;
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 200) begin
         #1;
         acc = pkt_rdy;
         @(negedge clk);
         cyc++;
      end
      check("beat_accepted", acc, 1);
      pkt_vld = 1'b0;
      pkt_sop = 1'b0;
      pkt_eop = 1'b0;
   endtask

   task automatic send(input logic [FLOW_W-1:0] fl, input string s, input logic with_eop);
      for (int i = 0; i < s.len(); i++)
         beat(s[i], i == 0, with_eop && (i == s.len() - 1), fl);
   endtask

   task automatic clear(input logic [FLOW_W-1:0] fl);
      int   cyc;
      logic acc;
      ctx_clr_vld  = 1'b1;
      ctx_clr_flow = fl;
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 200) begin
         #1;
         acc = ctx_clr_rdy;
         @(negedge clk);
         cyc++;
      end
      check("clear_accepted", acc, 1);
      ctx_clr_vld = 1'b0;
   endtask

   initial begin
      int   n;
      logic rdy_seen;
      rst = 1'b1;
      pkt_vld = 1'b0; pkt_sop = 1'b0; pkt_eop = 1'b0; pkt_data = '0; pkt_flow = '0;
      ctx_clr_vld = 1'b0; ctx_clr_flow = '0;
      repeat (3) @(negedge clk);

      // Reset values.
      check("rst_busy", busy, 1);
      check("rst_pkt_rdy", pkt_rdy, 0);
      check("rst_clr_rdy", ctx_clr_rdy, 0);
      check("rst_match_vld", match_vld, 0);
      check("rst_match_ofs", match_ofs, 0);
      check("rst_err", err, 0);
      check("rst_state_in_vld", m_state_in_vld, 0);

      // Init sweep: 64 busy cycles, no ready.
      rst = 1'b0;
      n = 0;
      rdy_seen = 1'b0;
      while (busy && n < 200) begin
         if (pkt_rdy || ctx_clr_rdy) rdy_seen = 1'b1;
         @(negedge clk);
         n++;
      end
      check("init_busy_cycles", n, 64);
      check("init_no_ready", rdy_seen, 0);
      check("idle_busy", busy, 0);
      check("idle_clr_rdy", ctx_clr_rdy, 1);

      // Flow 3 "USER ": restore 0, match at ofs 4.
      rq.push_back(11'd0);
      mq.push_back('{flow: 6'd3, ofs: 16'd4});
      send(6'd3, "USER ", 1'b1);

      // Interleaved flows 5/7/5: flow 5 resumes at state 2.
      rq.push_back(11'd0);
      send(6'd5, "US", 1'b1);
      rq.push_back(11'd0);
      send(6'd7, "xx", 1'b1);
      rq.push_back(11'd2);
      mq.push_back('{flow: 6'd5, ofs: 16'd2});
      send(6'd5, "ER ", 1'b1);

      // Single-beat SOP+EOP on flow 9 saves state 1, seen on the next flow-9 restore.
      rq.push_back(11'd0);
      send(6'd9, "U", 1'b1);
      rq.push_back(11'd1);
      send(6'd9, "S", 1'b1);

      // Flow 5 left in accept state 5; re-partial it to 2, clear, then expect 0.
      rq.push_back(11'd5);
      send(6'd5, "US", 1'b1);
      clear(6'd5);
      rq.push_back(11'd0);
      send(6'd5, "x", 1'b1);

      // Missing EOP on flow 11: SOP of flow 12 aborts it, flow 11 saved at state 2.
      rq.push_back(11'd0);
      send(6'd11, "US", 1'b0);
      err_exp++;
      rq.push_back(11'd0);
      send(6'd12, "x", 1'b1);
      rq.push_back(11'd2);
      mq.push_back('{flow: 6'd11, ofs: 16'd2});
      send(6'd11, "ER ", 1'b1);

      // Non-SOP beat in IDLE: dropped with an error pulse.
      err_exp++;
      beat(8'h7a, 1'b0, 1'b0, 6'd0);

      repeat (10) @(negedge clk);
      check("restores_outstanding", rq.size(), 0);
      check("matches_outstanding", mq.size(), 0);
      check("errors_outstanding", err_exp, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
